upsizer_packer: RTL
===================

Name: upsizer_packer

Overview:
- Upstream neighbour of the 1024->256 downsizer.
- Collects RATIO narrow beats of IN_W bits into one wide OUT_W word, and presents that word on the downsizer's input side with a valid/ready handshake.
- Supports early flush of a partial word via in_last; unused beats are zero-padded and flagged in a keep mask.

Parameters:
- IN_W, 256, width of one input beat in bits.
- RATIO, 4, beats per output word; must be >= 2.
- OUT_W = IN_W*RATIO (1024), derived localparam, not overridable.
- CNT_W, 16, width of the emitted-word counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- inp_data  in  IN_W  input beat.
- valid_in  in  1  beat valid.
- in_last  in  1  beat closes the current word early; qualified by valid_in.
- in_ready  out  1  beat accepted when valid_in && in_ready.
- data_out  out  OUT_W  packed word.
- out_en  out  1  data_out valid; held until accepted.
- out_ready  in  1  downstream accepts when out_en && out_ready.
- out_keep  out  RATIO  bit i=1 means beat slot i holds real data.
- word_cnt  out  CNT_W  number of words accepted downstream; wraps modulo 2^CNT_W.

Behaviour:
- Reset, checked on the clk edge while rst=1:
  - data_out=0, out_en=0, out_keep=0, word_cnt=0.
  - Beat counter cnt=0; accumulator acc=0.
  - Reset mid-word discards the partial word with no output.
  - Reset with out_en=1 drops the pending word; word_cnt is not incremented.
- in_ready = !out_en || out_ready. It is combinational from out_en and out_ready only and never depends on valid_in or in_last.
- Beat placement: accepted beat k of a word (k=cnt) goes to acc[k*IN_W +: IN_W]; the first beat lands in the lowest slot.
- Non-completing accept (cnt<RATIO-1 and !in_last):
  - Write the slot, set keep bit k, cnt<=cnt+1.
- Completing accept (cnt==RATIO-1, or in_last=1):
  - Next cycle: data_out = acc merged with this beat; slots above k are 0.
  - out_keep = mask of slots 0..k; out_en=1.
  - Next cycle: cnt=0, acc=0, keep accumulator cleared.
  - Latency is 1 cycle from the completing beat to out_en.
- Output register:
  - out_en falls on the cycle after out_en && out_ready, unless a completing accept occurs on the same edge; then the new word loads and out_en stays 1 (back-to-back).
  - data_out and out_keep are stable while out_en && !out_ready.
- word_cnt increments on each out_en && out_ready and wraps 2^CNT_W-1 -> 0.
- Throughput: with out_ready held at 1, a sustained stream of one beat per cycle produces one word every RATIO cycles with no bubbles.
- in_last on a beat with cnt==RATIO-1 behaves the same as a normal completion; keep is all ones.
- valid_in=0 leaves all state unchanged; in_last is ignored when valid_in=0.
- No combinational path from inp_data to data_out.

Optional Feature:
- Macro: UPSIZER_MSB_FIRST_EN.
- Defined: beat k goes to slot RATIO-1-k, so the first beat lands in [OUT_W-1 -: IN_W]. out_keep bit RATIO-1-k marks it, and padding is in the low slots.
- Undefined: the low-slot-first ordering described above.
- Handshake, latency and counters are identical in both builds.

Test Plan:
- Reset then 4 beats A,B,C,D (values 256'h1..4) on consecutive cycles, out_ready=1 -> one cycle after D: out_en=1, data_out={D,C,B,A}, out_keep=4'b1111; word_cnt=1 the following cycle.
- 2 beats (256'hAA, 256'hBB), second with in_last=1 -> data_out={256'h0,256'h0,256'hBB,256'hAA}, out_keep=4'b0011.
- Word completes with out_ready=0 -> in_ready=0, and data_out and out_keep hold for 5 cycles. Raise out_ready -> accepted, out_en drops, in_ready=1.
- Continuous 12-beat stream with out_ready=1 -> 3 words at cycles 4, 8 and 12 after the first beat; no stalls; word_cnt=3.
- rst asserted after 2 beats, then 4 fresh beats -> the first output word contains only the fresh beats, keep=4'b1111, word_cnt=1.
- With UPSIZER_MSB_FIRST_EN, beats A,B with in_last on B -> data_out={A,B,0,0}, out_keep=4'b1100.

Source files
------------

// File: rtl/upsizer_packer.sv
// Packs RATIO narrow beats into one OUT_W word with valid/ready output and early flush via in_last.
// Define UPSIZER_MSB_FIRST_EN to place the first beat in the top slot instead of the bottom slot.
module upsizer_packer #(
    parameter int IN_W  = 256,
    parameter int RATIO = 4,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [IN_W-1:0]        inp_data,
    input  logic                   valid_in,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic [IN_W*RATIO-1:0]  data_out,
    output logic                   out_en,
    input  logic                   out_ready,
    output logic [RATIO-1:0]       out_keep,
    output logic [CNT_W-1:0]       word_cnt
);
    localparam int OUT_W = IN_W * RATIO;
    localparam int K_W   = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [K_W-1:0] LAST_K = K_W'(RATIO - 1);

    function automatic logic [K_W-1:0] slot_of(input logic [K_W-1:0] k);
`ifdef UPSIZER_MSB_FIRST_EN
        return LAST_K - k;
`else
        return k;
`endif
    endfunction

    logic [K_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic [RATIO-1:0] keep_acc_q, keep_acc_d;
    logic [OUT_W-1:0] data_q, data_d;
    logic [RATIO-1:0] keep_q, keep_d;
    logic             en_q, en_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;

    logic             accept, complete;
    logic [K_W-1:0]   slot;
    logic [OUT_W-1:0] merged_data;
    logic [RATIO-1:0] merged_keep;

    // in_ready depends only on the output register state, never on valid_in
    assign in_ready = !en_q || out_ready;
    assign data_out = data_q;
    assign out_en   = en_q;
    assign out_keep = keep_q;
    assign word_cnt = wcnt_q;

    always_comb begin
        accept      = valid_in && in_ready;
        complete    = accept && ((cnt_q == LAST_K) || in_last);
        slot        = slot_of(cnt_q);
        merged_data = acc_q;
        merged_keep = keep_acc_q;
        for (int s = 0; s < RATIO; s++) begin
            if (slot == K_W'(s)) begin
                merged_data[s*IN_W +: IN_W] = inp_data;
                merged_keep[s]              = 1'b1;
            end
        end

        cnt_d      = cnt_q;
        acc_d      = acc_q;
        keep_acc_d = keep_acc_q;
        data_d     = data_q;
        keep_d     = keep_q;
        en_d       = en_q;
        wcnt_d     = wcnt_q;

        if (en_q && out_ready) begin
            en_d   = 1'b0;
            wcnt_d = wcnt_q + 1'b1;
        end

        // A completing beat reloads the output register even on the handshake edge
        if (complete) begin
            data_d     = merged_data;
            keep_d     = merged_keep;
            en_d       = 1'b1;
            cnt_d      = '0;
            acc_d      = '0;
            keep_acc_d = '0;
        end else if (accept) begin
            acc_d      = merged_data;
            keep_acc_d = merged_keep;
            cnt_d      = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            keep_acc_q <= '0;
            data_q     <= '0;
            keep_q     <= '0;
            en_q       <= 1'b0;
            wcnt_q     <= '0;
        end else begin
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            keep_acc_q <= keep_acc_d;
            data_q     <= data_d;
            keep_q     <= keep_d;
            en_q       <= en_d;
            wcnt_q     <= wcnt_d;
        end
    end
endmodule
